// File: rtl/imm_ext_pkg.sv
// Shared types and constants for the immediate-extension unit.
package imm_ext_pkg;

  // Extension mode as carried alongside each immediate.
  typedef logic [1:0] imm_mode_t;

  localparam imm_mode_t MODE_SEXT   = 2'd0;
  localparam imm_mode_t MODE_ZEXT   = 2'd1;
  localparam imm_mode_t MODE_UPPER  = 2'd2;
  localparam imm_mode_t MODE_BRANCH = 2'd3;

  // Occupancy of the two-entry output buffer.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b01,
    StFull  = 2'b10
  } occ_state_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational width/mode arithmetic for the immediate-extension unit.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned BR_SH = 2
) (
  input  logic [IN_W-1:0]  imm_i,
  input  logic [1:0]       mode_i,
  output logic [OUT_W-1:0] ext_o
);

  localparam int unsigned PadW = OUT_W - IN_W;

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] upper;
  logic [OUT_W-1:0] branch;

  assign sext   = {{PadW{imm_i[IN_W-1]}}, imm_i};
  assign zext   = {{PadW{1'b0}}, imm_i};
  assign upper  = {imm_i, {PadW{1'b0}}};
  // Word-offset scaling; bits shifted past OUT_W-1 are simply dropped.
  assign branch = sext << BR_SH;

  // Select the extension flavour requested by the decoder.
  always_comb begin
    ext_o = sext;
    unique case (mode_i)
      MODE_SEXT:   ext_o = sext;
      MODE_ZEXT:   ext_o = zext;
      MODE_UPPER:  ext_o = upper;
      MODE_BRANCH: ext_o = branch;
    endcase
  end

endmodule

// File: rtl/imm_ext_unit.sv
// Registered immediate extender with a two-entry valid/ready output buffer.
// in_ready is a function of occupancy only, so the producer never sees a
// combinational path from out_ready.
module imm_ext_unit
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned BR_SH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic [1:0]       out_mode
);

  occ_state_e       state_q, state_d;
  logic [OUT_W-1:0] head_imm_q, head_imm_d;
  logic [OUT_W-1:0] tail_imm_q, tail_imm_d;
  imm_mode_t        head_mode_q, head_mode_d;
  imm_mode_t        tail_mode_q, tail_mode_d;

  logic [OUT_W-1:0] ext_imm;
  logic             push;
  logic             pop;

  imm_ext_core #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .BR_SH(BR_SH)
  ) u_core (
    .imm_i (in_imm),
    .mode_i(in_mode),
    .ext_o (ext_imm)
  );

  assign in_ready  = (state_q != StFull);
  assign out_valid = (state_q != StEmpty);
  assign out_imm   = head_imm_q;
  assign out_mode  = head_mode_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Occupancy FSM and head/tail data movement.
  always_comb begin
    state_d     = state_q;
    head_imm_d  = head_imm_q;
    head_mode_d = head_mode_q;
    tail_imm_d  = tail_imm_q;
    tail_mode_d = tail_mode_q;

    case (state_q)
      StEmpty: begin
        if (push) begin
          head_imm_d  = ext_imm;
          head_mode_d = in_mode;
          state_d     = StOne;
        end
      end
      StOne: begin
        if (push && pop) begin
          // Old head leaves as the new entry takes its place.
          head_imm_d  = ext_imm;
          head_mode_d = in_mode;
        end else if (push) begin
          tail_imm_d  = ext_imm;
          tail_mode_d = in_mode;
          state_d     = StFull;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        // push cannot occur here since in_ready is low.
        if (pop) begin
          head_imm_d  = tail_imm_q;
          head_mode_d = tail_mode_q;
          state_d     = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase

    // Flush wins over any push in the same cycle; stale data is masked by out_valid.
    if (flush) begin
      state_d = StEmpty;
    end
  end

  // State and buffer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      head_imm_q  <= '0;
      head_mode_q <= MODE_SEXT;
      tail_imm_q  <= '0;
      tail_mode_q <= MODE_SEXT;
    end else begin
      state_q     <= state_d;
      head_imm_q  <= head_imm_d;
      head_mode_q <= head_mode_d;
      tail_imm_q  <= tail_imm_d;
      tail_mode_q <= tail_mode_d;
    end
  end

endmodule
